// File: rtl/udp_fifo_pkt_sched.sv
// Packet scheduler between the Ethernet-side sync FIFO read port and udp_tx.
// Launches a full packet when PKT_WORDS are buffered, or a partial one after an idle timeout.
module udp_fifo_pkt_sched #(
  parameter int DATA_W    = 32,
  parameter int LVL_W     = 12,
  parameter int PKT_WORDS = 256,
  parameter int TIMEOUT   = 4096,
  parameter int TO_W      = 16
) (
  input  logic              clk,
  input  logic              tb_rst,
  input  logic              enable,
  input  logic [LVL_W-1:0]  fifo_rd_level,
  input  logic              fifo_rd_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              udp_tx_start,
  output logic [15:0]       udp_tx_byte_num,
  input  logic              udp_tx_req,
  output logic [DATA_W-1:0] udp_tx_data,
  input  logic              udp_tx_done,
  output logic [15:0]       pkt_cnt,
  output logic              underrun_err,
  output logic              overrun_err
);

  // state     | meaning
  // IDLE      | waiting for enable
  // ARM       | watching water level, timing partial packets
  // START     | one-cycle start pulse, words_left loaded
  // SEND      | converting udp_tx_req into FIFO reads
  // WAIT_DONE | all words granted, waiting for udp_tx_done
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam logic [LVL_W-1:0] PKT_LVL = LVL_W'(PKT_WORDS);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state, state_next;
  logic [TO_W-1:0]   timer;
  logic [LVL_W-1:0]  words_q;
  logic [LVL_W-1:0]  words_left;
  logic [LVL_W-1:0]  launch_words;
  logic              lvl_full, lvl_partial, timeout_hit, launch;
  logic              left_zero;

  assign lvl_full     = (fifo_rd_level >= PKT_LVL);
  assign lvl_partial  = (fifo_rd_level != '0) && !lvl_full;
  assign timeout_hit  = (timer == TO_LAST) && (fifo_rd_level != '0);
  assign launch       = (state == ARM) && enable && (lvl_full || timeout_hit);
  assign launch_words = lvl_full ? PKT_LVL : fifo_rd_level;
  assign left_zero    = (words_left == '0);

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (enable) state_next = ARM;
      ARM: begin
        if (!enable)                      state_next = IDLE;
        else if (lvl_full || timeout_hit) state_next = START;
      end
      START:     state_next = SEND;
      SEND: begin
        if (udp_tx_done) state_next = IDLE;
        else if (left_zero || (fifo_rd_en && words_left == LVL_W'(1)))
          state_next = WAIT_DONE;
      end
      WAIT_DONE: if (udp_tx_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en   = (state == SEND) && udp_tx_req && !left_zero && !fifo_rd_empty;
    udp_tx_start = (state == START);
    udp_tx_data  = fifo_rd_data;
  end

  // Timer only runs while a partial packet sits in the FIFO and we stay armed.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      timer <= '0;
    end else if (state == ARM && state_next == ARM && lvl_partial) begin
      timer <= timer + TO_W'(1);
    end else begin
      timer <= '0;
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      words_q         <= '0;
      udp_tx_byte_num <= '0;
    end else if (launch) begin
      words_q         <= launch_words;
      udp_tx_byte_num <= 16'(launch_words) << 2;
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      words_left <= '0;
    end else if (state == START) begin
      words_left <= words_q;
    end else if (state == SEND && udp_tx_done) begin
      words_left <= '0;
    end else if (fifo_rd_en) begin
      words_left <= words_left - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      pkt_cnt      <= '0;
      underrun_err <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      if (state == START) pkt_cnt <= pkt_cnt + 16'd1;
      if ((state == SEND || state == WAIT_DONE) && udp_tx_req && left_zero)
        overrun_err <= 1'b1;
      if (state == SEND && udp_tx_req && !left_zero && fifo_rd_empty)
        underrun_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_fifo_pkt_sched.sv
// Bench for udp_fifo_pkt_sched: a queue-like FIFO model and a udp_tx request model
// with random payload and random request gaps.
module tb_udp_fifo_pkt_sched;

  logic        clk = 1'b0;
  logic        tb_rst;
  logic        enable;
  logic [11:0] fifo_rd_level;
  logic        fifo_rd_empty;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic        udp_tx_start;
  logic [15:0] udp_tx_byte_num;
  logic        udp_tx_req;
  logic [31:0] udp_tx_data;
  logic        udp_tx_done;
  logic [15:0] pkt_cnt;
  logic        underrun_err;
  logic        overrun_err;

  int vectors = 0;
  int miscompares = 0;

  // FIFO model: circular buffer, writes from the stimulus process, reads from the clocked model
  logic [31:0] mem [0:4095];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic        flush = 1'b0;
  logic        force_empty = 1'b0;

  logic        exp_over = 1'b0;
  logic        exp_under = 1'b0;
  int          exp_pkt = 0;

  always #5 clk = ~clk;

  assign fifo_rd_level = 12'(wr_ptr - rd_ptr);
  assign fifo_rd_empty = (wr_ptr == rd_ptr) || force_empty;

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr % 4096];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  udp_fifo_pkt_sched dut (
    .clk             (clk),
    .tb_rst          (tb_rst),
    .enable          (enable),
    .fifo_rd_level   (fifo_rd_level),
    .fifo_rd_empty   (fifo_rd_empty),
    .fifo_rd_data    (fifo_rd_data),
    .fifo_rd_en      (fifo_rd_en),
    .udp_tx_start    (udp_tx_start),
    .udp_tx_byte_num (udp_tx_byte_num),
    .udp_tx_req      (udp_tx_req),
    .udp_tx_data     (udp_tx_data),
    .udp_tx_done     (udp_tx_done),
    .pkt_cnt         (pkt_cnt),
    .underrun_err    (underrun_err),
    .overrun_err     (overrun_err)
  );

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 4096] = $urandom;
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic flush_fifo();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (udp_tx_start === 1'b1) break;
    end
    vectors++;
    if (udp_tx_start !== 1'b1) begin
      miscompares++;
      $display("FAIL start_timeout: no udp_tx_start within %0d cycles", budget);
    end else begin
      exp_pkt++;
    end
  endtask

  // Drives n_req requests (optionally with random gaps), forcing empty for request indices
  // emp_from..emp_to, and checks every read enable, payload word and error flag.
  task automatic do_packet(input int exp_words, input int n_req, input bit gaps,
                           input int emp_from, input int emp_to, output int nreads);
    int          left;
    int unsigned idx;
    logic        exp_en;
    left   = exp_words;
    idx    = rd_ptr;
    nreads = 0;
    @(negedge clk);
    enable = 1'b0;
    vectors++;
    if (udp_tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL start_width: start=%b expected 0 one cycle after pulse", udp_tx_start);
    end
    for (int i = 0; i < n_req; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      force_empty = (i >= emp_from) && (i <= emp_to);
      udp_tx_req  = 1'b1;
      #1;
      exp_en = (left > 0) && (wr_ptr != rd_ptr) && !force_empty;
      vectors++;
      if (fifo_rd_en !== exp_en) begin
        miscompares++;
        $display("FAIL rd_en req=%0d: got %b expected %b", i, fifo_rd_en, exp_en);
      end
      vectors++;
      if (overrun_err !== exp_over || underrun_err !== exp_under) begin
        miscompares++;
        $display("FAIL err_flags req=%0d: got ovr=%b und=%b expected ovr=%b und=%b",
                 i, overrun_err, underrun_err, exp_over, exp_under);
      end
      if (left == 0) exp_over = 1'b1;
      else if (!exp_en) exp_under = 1'b1;
      @(negedge clk);
      udp_tx_req  = 1'b0;
      force_empty = 1'b0;
      if (exp_en) begin
        vectors++;
        if (udp_tx_data !== mem[idx % 4096]) begin
          miscompares++;
          $display("FAIL data word=%0d: got %h expected %h", nreads, udp_tx_data, mem[idx % 4096]);
        end
        idx++;
        left--;
        nreads++;
      end
    end
    vectors++;
    if (overrun_err !== exp_over || underrun_err !== exp_under) begin
      miscompares++;
      $display("FAIL err_final: got ovr=%b und=%b expected ovr=%b und=%b",
               overrun_err, underrun_err, exp_over, exp_under);
    end
    vectors++;
    if (udp_tx_byte_num !== 16'(exp_words * 4)) begin
      miscompares++;
      $display("FAIL byte_num_hold: got %0d expected %0d", udp_tx_byte_num, exp_words * 4);
    end
    udp_tx_done = 1'b1;
    @(negedge clk);
    udp_tx_done = 1'b0;
    vectors++;
    if (pkt_cnt !== 16'(exp_pkt)) begin
      miscompares++;
      $display("FAIL pkt_cnt: got %0d expected %0d", pkt_cnt, exp_pkt);
    end
  endtask

  task automatic launch_and_check(input int n_push, input int budget, input int exp_cycles,
                                  input int exp_words);
    int cycles;
    flush_fifo();
    push_words(n_push);
    enable = 1'b1;
    wait_start(budget, cycles);
    vectors++;
    if (cycles !== exp_cycles) begin
      miscompares++;
      $display("FAIL start_latency: got %0d cycles expected %0d", cycles, exp_cycles);
    end
    vectors++;
    if (udp_tx_byte_num !== 16'(exp_words * 4)) begin
      miscompares++;
      $display("FAIL byte_num: got %0d expected %0d", udp_tx_byte_num, exp_words * 4);
    end
  endtask

  task automatic test_reset();
    tb_rst = 1'b1;
    #1;
    vectors++;
    if ({fifo_rd_en, udp_tx_start, udp_tx_byte_num, pkt_cnt, underrun_err, overrun_err} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: rd_en=%b start=%b bytes=%0d cnt=%0d und=%b ovr=%b",
               fifo_rd_en, udp_tx_start, udp_tx_byte_num, pkt_cnt, underrun_err, overrun_err);
    end
    repeat (3) @(negedge clk);
    tb_rst    = 1'b0;
    exp_pkt   = 0;
    exp_over  = 1'b0;
    exp_under = 1'b0;
  endtask

  task automatic test_full_pkt();
    int n;
    launch_and_check(300, 20, 2, 256);
    do_packet(256, 256, 1'b1, -1, -1, n);
    vectors++;
    if (n !== 256) begin
      miscompares++;
      $display("FAIL full_reads: got %0d expected 256", n);
    end
  endtask

  task automatic test_timeout();
    int n;
    launch_and_check(10, 5000, 4097, 10);
    do_packet(10, 10, 1'b1, -1, -1, n);
    vectors++;
    if (n !== 10) begin
      miscompares++;
      $display("FAIL timeout_reads: got %0d expected 10", n);
    end
  endtask

  task automatic test_overrun();
    int n;
    launch_and_check(300, 20, 2, 256);
    do_packet(256, 257, 1'b0, -1, -1, n);
    vectors++;
    if (n !== 256 || overrun_err !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun: got reads=%0d ovr=%b expected 256 and 1", n, overrun_err);
    end
  endtask

  // Five requests are starved mid-packet; the 256 grants must still all be available afterwards.
  task automatic test_underrun();
    int n;
    test_reset();
    launch_and_check(300, 20, 2, 256);
    do_packet(256, 261, 1'b0, 5, 9, n);
    vectors++;
    if (n !== 256 || underrun_err !== 1'b1 || overrun_err !== 1'b0) begin
      miscompares++;
      $display("FAIL underrun: got reads=%0d und=%b ovr=%b expected 256 1 0",
               n, underrun_err, overrun_err);
    end
  endtask

  task automatic test_enable_drop();
    int   n;
    logic seen;
    launch_and_check(300, 20, 2, 256);
    do_packet(256, 256, 1'b1, -1, -1, n);
    push_words(300);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (udp_tx_start === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || pkt_cnt !== 16'(exp_pkt)) begin
      miscompares++;
      $display("FAIL idle_hold: got start_seen=%b cnt=%0d expected 0 and %0d", seen, pkt_cnt, exp_pkt);
    end
    udp_tx_req = 1'b1;
    #1;
    vectors++;
    if (fifo_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_req_rd: got %b expected 0", fifo_rd_en);
    end
    @(negedge clk);
    udp_tx_req = 1'b0;
    vectors++;
    if (overrun_err !== exp_over || underrun_err !== exp_under) begin
      miscompares++;
      $display("FAIL idle_req_flags: got ovr=%b und=%b expected ovr=%b und=%b",
               overrun_err, underrun_err, exp_over, exp_under);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    launch_and_check(300, 20, 2, 256);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      udp_tx_req = 1'b1;
      @(negedge clk);
    end
    tb_rst = 1'b1;
    #1;
    vectors++;
    if ({fifo_rd_en, udp_tx_start, pkt_cnt, underrun_err, overrun_err} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_mid: rd_en=%b start=%b cnt=%0d und=%b ovr=%b expected all 0",
               fifo_rd_en, udp_tx_start, pkt_cnt, underrun_err, overrun_err);
    end
    @(negedge clk);
    udp_tx_req = 1'b0;
    tb_rst     = 1'b0;
    exp_pkt    = 0;
    exp_over   = 1'b0;
    exp_under  = 1'b0;
    launch_and_check(300, 20, 2, 256);
    do_packet(256, 256, 1'b1, -1, -1, n);
    vectors++;
    if (n !== 256) begin
      miscompares++;
      $display("FAIL post_reset_reads: got %0d expected 256", n);
    end
  endtask

  initial begin
    enable       = 1'b0;
    udp_tx_req   = 1'b0;
    udp_tx_done  = 1'b0;
    fifo_rd_data = '0;
    tb_rst       = 1'b0;
    test_reset();
    test_full_pkt();
    test_timeout();
    test_overrun();
    test_underrun();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
